iob_ram_2p_be_clr: RTL and testbench

Parametrised two-port (one write, one read) synchronous RAM with per-byte write strobes, same-address write-to-read forwarding, an optional output pipeline register and a built-in clear engine that zeroes the whole array after reset or on request. It is the general-purpose register-file and buffer store for cores and peripherals that need byte-granular writes and known-zero contents without a software init loop.

---
 rtl/iob_ram_2p_be_clr.sv | 157 +++++++++++++++
 tb/tb_iob_ram_2p_be_clr.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_ram_2p_be_clr.sv
// iob_ram_2p_be_clr
// Two-port (one write, one read) synchronous RAM with per-byte write strobes,
// same-address write-to-read forwarding, an optional output register stage and
// a clear engine that zeroes the whole array after reset or on request.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset
//   w_en     - write enable
//   w_strb   - byte write strobes, bit k covers w_data[8k+7:8k]
//   w_addr   - write address
//   w_data   - write data
//   r_en     - read enable
//   r_addr   - read address
//   r_data   - read data, holds when no read completes
//   r_valid  - one-cycle pulse, r_data carries a read result
//   clr_req  - start a full clear (level, sampled each cycle)
//   busy     - clear engine active, user accesses are ignored
module iob_ram_2p_be_clr #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned OUT_REG  = 0,
    parameter int unsigned INIT_CLR = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                w_en,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [DATA_W-1:0]   w_data,
    input  logic                r_en,
    input  logic [ADDR_W-1:0]   r_addr,
    output logic [DATA_W-1:0]   r_data,
    output logic                r_valid,
    input  logic                clr_req,
    output logic                busy
);

    localparam int unsigned NumLanes = DATA_W / 8;
    localparam int unsigned Depth    = 1 << ADDR_W;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;

    logic [DATA_W-1:0]   mem [Depth];

    logic                wr_fire;
    logic                rd_fire;
    logic [DATA_W-1:0]   rd_word;

    logic                s1_valid_q;
    logic [DATA_W-1:0]   s1_data_q;

    assign busy = (state_q == StClear);

    // A clear request in IDLE wins over a same-cycle write.
    assign wr_fire = w_en && !busy && !clr_req;
    assign rd_fire = r_en && !busy;

    // Clear engine
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d    = StClear;
                    clr_addr_d = '0;
                end
            end
            StClear: begin
                // Natural wrap of the counter lands back on 0 as we leave CLEAR.
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == {ADDR_W{1'b1}}) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= (INIT_CLR != 0) ? StClear : StIdle;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Array: never reset, written only outside reset by the clear engine or the user.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (busy) begin
                mem[clr_addr_q] <= '0;
            end else if (wr_fire) begin
                for (int k = 0; k < NumLanes; k++) begin
                    if (w_strb[k]) begin
                        mem[w_addr][8*k +: 8] <= w_data[8*k +: 8];
                    end
                end
            end
        end
    end

    // Read word with per-lane forwarding from a same-cycle write.
    always_comb begin
        rd_word = mem[r_addr];
        if (wr_fire && (w_addr == r_addr)) begin
            for (int k = 0; k < NumLanes; k++) begin
                if (w_strb[k]) begin
                    rd_word[8*k +: 8] = w_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_fire;
            if (rd_fire) begin
                s1_data_q <= rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic              s2_valid_q;
        logic [DATA_W-1:0] s2_data_q;

        // Advances regardless of busy so in-flight reads still complete.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign r_valid = s2_valid_q;
        assign r_data  = s2_data_q;
    end else begin : g_no_out_reg
        assign r_valid = s1_valid_q;
        assign r_data  = s1_data_q;
    end

endmodule

// File: tb/tb_iob_ram_2p_be_clr.sv
// Testbench for iob_ram_2p_be_clr: one instance with OUT_REG=0 and one with
// OUT_REG=1 share the same stimulus; each is checked against hand-computed values.
module tb_iob_ram_2p_be_clr;

    logic        clk;
    logic        rst_n;
    logic        w_en;
    logic [3:0]  w_strb;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic        r_en;
    logic [3:0]  r_addr;
    logic        clr_req;

    logic [31:0] r_data0, r_data1;
    logic        r_valid0, r_valid1;
    logic        busy0, busy1;

    int asserts;
    int fails;

    iob_ram_2p_be_clr #(
        .DATA_W  (32),
        .ADDR_W  (4),
        .OUT_REG (0),
        .INIT_CLR(1)
    ) u_dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .w_en   (w_en),
        .w_strb (w_strb),
        .w_addr (w_addr),
        .w_data (w_data),
        .r_en   (r_en),
        .r_addr (r_addr),
        .r_data (r_data0),
        .r_valid(r_valid0),
        .clr_req(clr_req),
        .busy   (busy0)
    );

    iob_ram_2p_be_clr #(
        .DATA_W  (32),
        .ADDR_W  (4),
        .OUT_REG (1),
        .INIT_CLR(1)
    ) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .w_en   (w_en),
        .w_strb (w_strb),
        .w_addr (w_addr),
        .w_data (w_data),
        .r_en   (r_en),
        .r_addr (r_addr),
        .r_data (r_data1),
        .r_valid(r_valid1),
        .clr_req(clr_req),
        .busy   (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        w_en   = 1'b1;
        w_addr = addr;
        w_data = data;
        w_strb = strb;
        tick();
        w_en   = 1'b0;
        w_strb = 4'h0;
    endtask

    // Single isolated read: dut0 answers after one edge, dut1 after two.
    task automatic do_read(input logic [3:0] addr, input logic [31:0] exp);
        r_en   = 1'b1;
        r_addr = addr;
        tick();
        r_en = 1'b0;
        chk("rd_valid0", {31'd0, r_valid0}, 32'd1);
        chk("rd_data0", r_data0, exp);
        chk("rd_valid1_early", {31'd0, r_valid1}, 32'd0);
        tick();
        chk("rd_valid0_off", {31'd0, r_valid0}, 32'd0);
        chk("rd_hold0", r_data0, exp);
        chk("rd_valid1", {31'd0, r_valid1}, 32'd1);
        chk("rd_data1", r_data1, exp);
    endtask

    int n;

    initial begin
        asserts = 0;
        fails   = 0;
        rst_n   = 1'b0;
        w_en    = 1'b0;
        w_strb  = 4'h0;
        w_addr  = 4'h0;
        w_data  = 32'h0;
        r_en    = 1'b0;
        r_addr  = 4'h0;
        clr_req = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_r_data0", r_data0, 32'h0);
        chk("rst_r_data1", r_data1, 32'h0);
        chk("rst_r_valid0", {31'd0, r_valid0}, 32'd0);
        chk("rst_r_valid1", {31'd0, r_valid1}, 32'd0);
        chk("rst_busy0", {31'd0, busy0}, 32'd1);
        chk("rst_busy1", {31'd0, busy1}, 32'd1);

        // Initial clear after reset release lasts 16 cycles
        rst_n = 1'b1;
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            tick();
        end
        chk("init_clr_cycles", n, 32'd16);
        chk("init_clr_busy1", {31'd0, busy1}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            do_read(i[3:0], 32'h0);
        end

        // Full-word writes, then byte-strobed merge and strobe-zero no-op
        for (int i = 0; i < 16; i++) begin
            do_write(i[3:0], 32'h20 + i, 4'hF);
        end
        do_write(4'd3, 32'hAABBCCDD, 4'b0101);
        do_read(4'd3, 32'h00BB00DD);
        do_write(4'd2, 32'hFFFFFFFF, 4'b0000);
        do_read(4'd2, 32'h00000022);
        do_read(4'd9, 32'h00000029);

        // Same-cycle write and read to address 5 (forwarding)
        w_en   = 1'b1;
        w_addr = 4'd5;
        w_data = 32'h11223344;
        w_strb = 4'b1100;
        r_en   = 1'b1;
        r_addr = 4'd5;
        tick();
        w_en   = 1'b0;
        w_strb = 4'h0;
        r_en   = 1'b0;
        chk("fwd_valid0", {31'd0, r_valid0}, 32'd1);
        chk("fwd_data0", r_data0, 32'h11220025);
        tick();
        chk("fwd_valid1", {31'd0, r_valid1}, 32'd1);
        chk("fwd_data1", r_data1, 32'h11220025);
        do_read(4'd5, 32'h11220025);

        // r_en low: outputs hold, no valid pulses
        for (int i = 0; i < 16; i++) begin
            r_addr = i[3:0];
            tick();
            chk("idle_valid0", {31'd0, r_valid0}, 32'd0);
            chk("idle_valid1", {31'd0, r_valid1}, 32'd0);
            chk("idle_hold0", r_data0, 32'h11220025);
            chk("idle_hold1", r_data1, 32'h11220025);
        end

        // Restore plain contents, then back-to-back reads
        do_write(4'd3, 32'h23, 4'hF);
        do_write(4'd5, 32'h25, 4'hF);
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                r_en   = 1'b1;
                r_addr = i[3:0];
            end else begin
                r_en = 1'b0;
            end
            tick();
            if (i < 16) begin
                chk("b2b_valid0", {31'd0, r_valid0}, 32'd1);
                chk("b2b_data0", r_data0, 32'h20 + i);
            end else begin
                chk("b2b_valid0_off", {31'd0, r_valid0}, 32'd0);
            end
            if (i >= 1 && i <= 16) begin
                chk("b2b_valid1", {31'd0, r_valid1}, 32'd1);
                chk("b2b_data1", r_data1, 32'h20 + i - 1);
            end else begin
                chk("b2b_valid1_off", {31'd0, r_valid1}, 32'd0);
            end
        end

        // Clear request with a same-cycle write; accesses during busy ignored
        clr_req = 1'b1;
        w_en    = 1'b1;
        w_addr  = 4'd7;
        w_data  = 32'hDEADBEEF;
        w_strb  = 4'hF;
        tick();
        clr_req = 1'b0;
        w_en    = 1'b0;
        w_strb  = 4'h0;
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            chk("clr_valid0", {31'd0, r_valid0}, 32'd0);
            chk("clr_valid1", {31'd0, r_valid1}, 32'd0);
            w_en   = 1'b1;
            w_addr = n[3:0];
            w_data = 32'hFFFFFFFF;
            w_strb = 4'hF;
            r_en   = 1'b1;
            r_addr = n[3:0];
            tick();
        end
        w_en   = 1'b0;
        w_strb = 4'h0;
        r_en   = 1'b0;
        chk("clr_cycles", n, 32'd16);
        chk("clr_busy1", {31'd0, busy1}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            do_read(i[3:0], 32'h0);
        end

        // Reset pulse in the middle of a clear restarts it from address 0
        do_write(4'd7, 32'h77, 4'hF);
        do_read(4'd7, 32'h77);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        chk("mid_busy0", {31'd0, busy0}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid0", {31'd0, r_valid0}, 32'd0);
        chk("mid_rst_data0", r_data0, 32'h0);
        chk("mid_rst_data1", r_data1, 32'h0);
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            tick();
        end
        chk("restart_clr_cycles", n, 32'd16);
        do_read(4'd7, 32'h0);
        do_read(4'd15, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
